ccip_host_mem_responder: RTL and testbench
==========================================

Name: ccip_host_mem_responder

Overview:
- Host-side responder for the CCI-P request channels an AFU drives: accepts c0Tx line reads and c1Tx line writes, returns c0Rx read responses and c1Rx write acks.
- Backed by a local line memory with programmable read latency and response-rate throttling.
- Stands in for the FIU/host memory in AFU-level benches so the AFU read→compute→write loop closes without the ASE host model.

Parameters:
- ADDR_W, 42, cache-line address width (matches t_cci_clAddr).
- DEPTH, 256, memory lines of 512 bits; power of two.
- READ_LATENCY, 8, minimum cycles from read accept to c0Rx response; 1..32767.
- RSP_GAP, 0, minimum idle cycles between consecutive c0Rx responses.
- FIFO_DEPTH, 16, outstanding-read capacity; power of two, ≥8.
- ALMFULL_MARGIN, 4, free entries remaining when c0tx_almfull asserts.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- c0tx_valid  in  1  read request valid
- c0tx_addr  in  ADDR_W  read line address
- c0tx_mdata  in  16  read request tag
- c0tx_almfull  out  1  AFU must stop issuing reads
- c1tx_valid  in  1  write request valid
- c1tx_addr  in  ADDR_W  write line address
- c1tx_mdata  in  16  write request tag
- c1tx_data  in  512  write line data
- c1tx_almfull  out  1  tied 0
- c0rx_valid  out  1  read response valid (rdRsp)
- c0rx_mdata  out  16  echoed read tag
- c0rx_data  out  512  read line data
- c1rx_valid  out  1  write ack valid (wrRsp)
- c1rx_mdata  out  16  echoed write tag
- overflow_err  out  1  sticky: read accepted while FIFO full
- addr_err  out  1  sticky: address ≥ DEPTH seen on either channel

Behaviour:
- Reset (async assert, sync release): all outputs 0. FIFO emptied, gap counter, cycle counter, errors and pending ack cleared. Memory contents are not cleared.
- Index is addr[log2(DEPTH)-1:0]. Out of range means any upper address bit is set.
- Write, c1tx_valid at cycle T:
  - In range: mem[idx] ← c1tx_data at T.
  - Out of range: memory untouched, addr_err set.
  - Always acked: c1rx_valid=1 with c1rx_mdata at T+1, for exactly one cycle.
  - Back-to-back writes produce back-to-back acks.
- Read, c0tx_valid at cycle T:
  - Line data is captured at T, write-first. A same-cycle write to the same index returns the new data.
  - Out of range: data captured as all-zero, addr_err set, response still issued.
  - Entry {data, mdata, due=T+READ_LATENCY} pushed into the FIFO.
  - Free-running 16-bit cycle counter; due compare is wrap-safe, via the signed difference.
- Response issue:
  - Head pops when FIFO is non-empty, now−due ≥ 0, and gap counter = 0.
  - On pop: c0rx_valid=1 for one cycle with head mdata/data. Gap counter loads RSP_GAP and decrements to 0 on each following cycle.
  - Responses are in request order; minimum latency is exactly READ_LATENCY.
- Simultaneous push and pop: count unchanged. A push at full with no same-cycle pop is dropped, sets overflow_err, and produces no response.
- c0tx_almfull = (count ≥ FIFO_DEPTH−ALMFULL_MARGIN), registered from the post-update count.
- Reads and writes on the same cycle are independent. A c0Rx response and a c1Rx ack may coincide.
- Reset mid-operation: queued reads and pending acks are discarded without being issued.
- Idle encoding: c0rx_data and c0rx_mdata hold their last values when c0rx_valid=0; benches sample only on valid.

Optional Feature:
- Macro: CCIP_RESPONDER_STATS_EN.
- Defined: adds outputs rd_count, wr_count, rsp_count, each 32 bits, in the clk domain.
  - rd_count increments per accepted read (including dropped reads).
  - wr_count increments per write.
  - rsp_count increments per c0Rx response.
  - All saturate at 0xFFFF_FFFF and reset to 0.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Write then read: write addr 0x3, data {448'b0, 32'd42, 32'd1}, mdata 0x11; read addr 0x3 at T=10, mdata 0x22 → c1rx ack mdata 0x11 one cycle after the write; c0rx_valid at T=18 (READ_LATENCY=8) with the same data and mdata 0x22.
- Same-cycle RAW: mem[5]=0xAA..; write 0x55.. and read addr 5 on the same cycle → response carries 0x55...
- Throttle and order: RSP_GAP=2, 6 back-to-back reads with tags 0..5 → responses in tags 0..5, spaced exactly 3 cycles apart; first arrives at T+8.
- Fill and almfull: RSP_GAP=20, issue 13 reads → c0tx_almfull high after the 12th accept; 17 reads without pause → 17th dropped, overflow_err=1, exactly 16 responses.
- Out of range: read addr 0x100 with DEPTH=256 → zero-data response, addr_err=1; write to 0x100 → acked, mem unchanged.
- Reset mid-flight: 4 reads queued, assert reset for 1 cycle → outputs 0 immediately, no stale responses after release; a prior in-range write is still readable.

Source files
------------

// File: rtl/ccip_host_mem_responder.sv
// CCI-P host memory stand-in: c0Tx reads / c1Tx writes against a local line memory, with delayed, throttled c0Rx responses.
// Optional CCIP_RESPONDER_STATS_EN adds saturating rd/wr/rsp counters.
module ccip_host_mem_responder #(
  parameter int ADDR_W         = 42,
  parameter int DEPTH          = 256,
  parameter int READ_LATENCY   = 8,
  parameter int RSP_GAP        = 0,
  parameter int FIFO_DEPTH     = 16,
  parameter int ALMFULL_MARGIN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0tx_valid,
  input  logic [ADDR_W-1:0] c0tx_addr,
  input  logic [15:0]       c0tx_mdata,
  output logic              c0tx_almfull,
  input  logic              c1tx_valid,
  input  logic [ADDR_W-1:0] c1tx_addr,
  input  logic [15:0]       c1tx_mdata,
  input  logic [511:0]      c1tx_data,
  output logic              c1tx_almfull,
  output logic              c0rx_valid,
  output logic [15:0]       c0rx_mdata,
  output logic [511:0]      c0rx_data,
  output logic              c1rx_valid,
  output logic [15:0]       c1rx_mdata,
  output logic              overflow_err,
  output logic              addr_err
`ifdef CCIP_RESPONDER_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic [31:0]       rsp_count
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ALMFULL_CNT = CNT_W'(FIFO_DEPTH - ALMFULL_MARGIN);
  // Pop decision happens one cycle before the registered response appears.
  localparam logic [15:0] DUE_OFS  = 16'(READ_LATENCY - 1);
  localparam logic [15:0] GAP_LOAD = 16'(RSP_GAP);
  localparam bit CAN_BYPASS = (READ_LATENCY == 1);

  logic [511:0] mem [DEPTH];
  logic [511:0] fifo_data  [FIFO_DEPTH];
  logic [15:0]  fifo_mdata [FIFO_DEPTH];
  logic [15:0]  fifo_due   [FIFO_DEPTH];

  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_next;
  logic [15:0]        cyc, gap_cnt;
  logic signed [15:0] head_age;
  logic [IDX_W-1:0]   rd_idx, wr_idx;
  logic               rd_oor, wr_oor;
  logic [511:0]       rd_line;
  logic               head_ripe, pop, bypass, push, issue, drop;

  assign rd_idx = c0tx_addr[IDX_W-1:0];
  assign wr_idx = c1tx_addr[IDX_W-1:0];
  assign rd_oor = |c0tx_addr[ADDR_W-1:IDX_W];
  assign wr_oor = |c1tx_addr[ADDR_W-1:IDX_W];

  always_comb begin
    rd_line = '0;
    if (!rd_oor) begin
      if (c1tx_valid && !wr_oor && (wr_idx == rd_idx)) rd_line = c1tx_data;
      else                                             rd_line = mem[rd_idx];
    end
  end

  // Signed difference keeps the due test correct across counter wrap.
  assign head_age  = cyc - fifo_due[rd_ptr];
  assign head_ripe = (head_age >= 16'sd0);
  assign pop       = (count != '0) && head_ripe && (gap_cnt == '0);
  assign bypass    = CAN_BYPASS && c0tx_valid && (count == '0) && (gap_cnt == '0);
  assign issue     = pop || bypass;
  assign push      = c0tx_valid && !bypass && ((count != FULL_CNT) || pop);
  assign drop      = c0tx_valid && (count == FULL_CNT) && !pop;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (pop && !push) count_next = count - CNT_W'(1);
  end

  assign c1tx_almfull = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (c1tx_valid && !wr_oor) mem[wr_idx] <= c1tx_data;
      if (push) begin
        fifo_data[wr_ptr]  <= rd_line;
        fifo_mdata[wr_ptr] <= c0tx_mdata;
        fifo_due[wr_ptr]   <= cyc + DUE_OFS;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      gap_cnt      <= '0;
      c0tx_almfull <= 1'b0;
      c0rx_valid   <= 1'b0;
      c0rx_mdata   <= '0;
      c0rx_data    <= '0;
      c1rx_valid   <= 1'b0;
      c1rx_mdata   <= '0;
      overflow_err <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      cyc          <= cyc + 16'd1;
      count        <= count_next;
      c0tx_almfull <= (count_next >= ALMFULL_CNT);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (issue)               gap_cnt <= GAP_LOAD;
      else if (gap_cnt != '0)  gap_cnt <= gap_cnt - 16'd1;

      c0rx_valid <= issue;
      if (issue) begin
        c0rx_mdata <= bypass ? c0tx_mdata : fifo_mdata[rd_ptr];
        c0rx_data  <= bypass ? rd_line    : fifo_data[rd_ptr];
      end

      c1rx_valid <= c1tx_valid;
      if (c1tx_valid) c1rx_mdata <= c1tx_mdata;

      if (drop) overflow_err <= 1'b1;
      if ((c0tx_valid && rd_oor) || (c1tx_valid && wr_oor)) addr_err <= 1'b1;
    end
  end

`ifdef CCIP_RESPONDER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count  <= '0;
      wr_count  <= '0;
      rsp_count <= '0;
    end else begin
      if (c0tx_valid && (rd_count  != '1)) rd_count  <= rd_count  + 32'd1;
      if (c1tx_valid && (wr_count  != '1)) wr_count  <= wr_count  + 32'd1;
      if (issue      && (rsp_count != '1)) rsp_count <= rsp_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ccip_host_mem_responder.sv
// Bench for ccip_host_mem_responder: two instances (RSP_GAP 2 and 20) share stimulus and are checked every cycle against a queue model.
module tb_ccip_host_mem_responder;
  localparam int L = 8, FD = 16, MARGIN = 4;

  logic clk = 1'b0;
  logic reset;
  logic c0tx_valid, c1tx_valid;
  logic [41:0] c0tx_addr, c1tx_addr;
  logic [15:0] c0tx_mdata, c1tx_mdata;
  logic [511:0] c1tx_data;

  logic o_c0v [2], o_c0alm [2], o_c1alm [2], o_c1v [2], o_ovf [2], o_aerr [2];
  logic [15:0]  o_c0m [2], o_c1m [2];
  logic [511:0] o_c0d [2];

  always #5 clk = ~clk;

  ccip_host_mem_responder #(.ADDR_W(42), .DEPTH(256), .READ_LATENCY(L), .RSP_GAP(2),
                            .FIFO_DEPTH(FD), .ALMFULL_MARGIN(MARGIN)) u_fast (
    .clk(clk), .reset(reset),
    .c0tx_valid(c0tx_valid), .c0tx_addr(c0tx_addr), .c0tx_mdata(c0tx_mdata), .c0tx_almfull(o_c0alm[0]),
    .c1tx_valid(c1tx_valid), .c1tx_addr(c1tx_addr), .c1tx_mdata(c1tx_mdata), .c1tx_data(c1tx_data),
    .c1tx_almfull(o_c1alm[0]),
    .c0rx_valid(o_c0v[0]), .c0rx_mdata(o_c0m[0]), .c0rx_data(o_c0d[0]),
    .c1rx_valid(o_c1v[0]), .c1rx_mdata(o_c1m[0]),
    .overflow_err(o_ovf[0]), .addr_err(o_aerr[0]));

  ccip_host_mem_responder #(.ADDR_W(42), .DEPTH(256), .READ_LATENCY(L), .RSP_GAP(20),
                            .FIFO_DEPTH(FD), .ALMFULL_MARGIN(MARGIN)) u_slow (
    .clk(clk), .reset(reset),
    .c0tx_valid(c0tx_valid), .c0tx_addr(c0tx_addr), .c0tx_mdata(c0tx_mdata), .c0tx_almfull(o_c0alm[1]),
    .c1tx_valid(c1tx_valid), .c1tx_addr(c1tx_addr), .c1tx_mdata(c1tx_mdata), .c1tx_data(c1tx_data),
    .c1tx_almfull(o_c1alm[1]),
    .c0rx_valid(o_c0v[1]), .c0rx_mdata(o_c0m[1]), .c0rx_data(o_c0d[1]),
    .c1rx_valid(o_c1v[1]), .c1rx_mdata(o_c1m[1]),
    .overflow_err(o_ovf[1]), .addr_err(o_aerr[1]));

  // Reference model: per-instance list of pending reads with absolute ready cycles.
  typedef struct packed {
    logic [511:0] data;
    logic [15:0]  mdata;
    logic [31:0]  ready;
  } ent_t;

  ent_t         mq [2][32];
  int           mh [2], ms [2], next_ok [2];
  logic [511:0] m_mem [256];
  logic         exp_c0v [2], exp_alm [2], exp_ovf [2];
  logic [15:0]  exp_c0m [2];
  logic [511:0] exp_c0d [2];
  logic         exp_aerr, exp_c1v;
  logic [15:0]  exp_c1m;
  int           cyc = 0;
  int           n_checks = 0, n_fail = 0;

  function automatic int gap_of(input int i);
    return (i == 0) ? 2 : 20;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic rd_in, wr_in;
    logic [511:0] rdata;
    ent_t e;
    bit emitted, from_q, consumed;
    int pre;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        ms[i] = 0; mh[i] = 0; next_ok[i] = 0;
        exp_c0v[i] = 0; exp_alm[i] = 0; exp_ovf[i] = 0;
      end
      exp_aerr = 0; exp_c1v = 0;
      cyc++;
      return;
    end
    rd_in = (c0tx_addr < 42'd256);
    wr_in = (c1tx_addr < 42'd256);
    rdata = '0;
    if (c0tx_valid && rd_in)
      rdata = (c1tx_valid && wr_in && c1tx_addr == c0tx_addr) ? c1tx_data : m_mem[c0tx_addr[7:0]];
    if (c0tx_valid && !rd_in) exp_aerr = 1;
    exp_c1v = c1tx_valid;
    if (c1tx_valid) begin
      exp_c1m = c1tx_mdata;
      if (wr_in) m_mem[c1tx_addr[7:0]] = c1tx_data;
      else       exp_aerr = 1;
    end
    for (int i = 0; i < 2; i++) begin
      emitted = 0; from_q = 0; consumed = 0; pre = ms[i];
      exp_c0v[i] = 0;
      e = '0;
      if (cyc + 1 >= next_ok[i]) begin
        if (ms[i] > 0) begin
          e = mq[i][mh[i]];
          if (int'(e.ready) <= cyc + 1) begin
            emitted = 1; from_q = 1;
            mh[i] = (mh[i] + 1) % 32;
            ms[i]--;
          end
        end else if (c0tx_valid && (cyc + L <= cyc + 1)) begin
          e.data = rdata; e.mdata = c0tx_mdata;
          emitted = 1; consumed = 1;
        end
      end
      if (emitted) begin
        exp_c0v[i] = 1; exp_c0m[i] = e.mdata; exp_c0d[i] = e.data;
        next_ok[i] = cyc + 2 + gap_of(i);
      end
      if (c0tx_valid && !consumed) begin
        if (pre < FD || from_q) begin
          e.data = rdata; e.mdata = c0tx_mdata; e.ready = 32'(cyc + L);
          mq[i][(mh[i] + ms[i]) % 32] = e;
          ms[i]++;
        end else begin
          exp_ovf[i] = 1;
        end
      end
      exp_alm[i] = (ms[i] >= FD - MARGIN);
    end
    cyc++;
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("c0rx_valid[%0d]", i), 512'(o_c0v[i]), 512'(exp_c0v[i]));
      if (exp_c0v[i]) begin
        chk($sformatf("c0rx_mdata[%0d]", i), 512'(o_c0m[i]), 512'(exp_c0m[i]));
        chk($sformatf("c0rx_data[%0d]", i), o_c0d[i], exp_c0d[i]);
      end
      chk($sformatf("c0tx_almfull[%0d]", i), 512'(o_c0alm[i]), 512'(exp_alm[i]));
      chk($sformatf("overflow_err[%0d]", i), 512'(o_ovf[i]), 512'(exp_ovf[i]));
      chk($sformatf("addr_err[%0d]", i), 512'(o_aerr[i]), 512'(exp_aerr));
      chk($sformatf("c1tx_almfull[%0d]", i), 512'(o_c1alm[i]), 512'(0));
      chk($sformatf("c1rx_valid[%0d]", i), 512'(o_c1v[i]), 512'(exp_c1v));
      if (exp_c1v) chk($sformatf("c1rx_mdata[%0d]", i), 512'(o_c1m[i]), 512'(exp_c1m));
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    compare();
  end

  task automatic drive(input bit rv, input logic [41:0] ra, input logic [15:0] rm,
                       input bit wv, input logic [41:0] wa, input logic [15:0] wm,
                       input logic [511:0] wd);
    @(negedge clk);
    c0tx_valid = rv; c0tx_addr = ra; c0tx_mdata = rm;
    c1tx_valid = wv; c1tx_addr = wa; c1tx_mdata = wm; c1tx_data = wd;
    @(posedge clk);
  endtask

  task automatic idle();
    drive(0, '0, '0, 0, '0, '0, '0);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((ms[0] > 0 || ms[1] > 0 || cyc + 1 < next_ok[0] || cyc + 1 < next_ok[1]) && k < 2000) begin
      idle();
      k++;
    end
    idle();
    if (k >= 2000) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: queues still busy after %0d cycles, required empty", k);
    end
  endtask

  // Called right after the edge that accepted a read; response must land exactly L cycles later.
  task automatic expect_rsp(input string name, input logic [15:0] tag, input logic [511:0] data);
    repeat (L - 2) idle();
    #2;
    chk({name, "_early"}, 512'(o_c0v[0]), 512'(0));
    idle();
    #2;
    chk({name, "_valid"}, 512'(o_c0v[0]), 512'(1));
    chk({name, "_mdata"}, 512'(o_c0m[0]), 512'(tag));
    chk({name, "_data"}, o_c0d[0], data);
  endtask

  task automatic chk_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_c0v[%0d]", name, i), 512'(o_c0v[i]), 512'(0));
      chk($sformatf("%s_c0m[%0d]", name, i), 512'(o_c0m[i]), 512'(0));
      chk($sformatf("%s_c0d[%0d]", name, i), o_c0d[i], 512'(0));
      chk($sformatf("%s_alm[%0d]", name, i), 512'(o_c0alm[i]), 512'(0));
      chk($sformatf("%s_ovf[%0d]", name, i), 512'(o_ovf[i]), 512'(0));
      chk($sformatf("%s_aerr[%0d]", name, i), 512'(o_aerr[i]), 512'(0));
      chk($sformatf("%s_c1v[%0d]", name, i), 512'(o_c1v[i]), 512'(0));
      chk($sformatf("%s_c1m[%0d]", name, i), 512'(o_c1m[i]), 512'(0));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] wd;
    logic [41:0]  ra, wa;
    int           offs [$];
    logic [15:0]  tags [$];
    int           k, seen;
    bit           rv, wv;

    reset = 1'b1;
    c0tx_valid = 0; c0tx_addr = '0; c0tx_mdata = '0;
    c1tx_valid = 0; c1tx_addr = '0; c1tx_mdata = '0; c1tx_data = '0;
    repeat (3) @(posedge clk);
    #2;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int a = 0; a < 256; a++) begin
      for (int w = 0; w < 16; w++) wd[w*32 +: 32] = $urandom();
      drive(0, '0, '0, 1, 42'(a), 16'(a), wd);
    end

    // Write then read back
    wait_drain();
    drive(0, '0, '0, 1, 42'h3, 16'h11, {448'b0, 32'd42, 32'd1});
    #2;
    chk("t1_ack_valid", 512'(o_c1v[0]), 512'(1));
    chk("t1_ack_mdata", 512'(o_c1m[0]), 512'(16'h11));
    idle();
    #2;
    chk("t1_ack_once", 512'(o_c1v[0]), 512'(0));
    drive(1, 42'h3, 16'h22, 0, '0, '0, '0);
    expect_rsp("t1", 16'h22, {448'b0, 32'd42, 32'd1});

    // Same-cycle write/read to one index returns the new line
    wait_drain();
    drive(0, '0, '0, 1, 42'h5, 16'h30, {64{8'hAA}});
    drive(1, 42'h5, 16'h33, 1, 42'h5, 16'h34, {64{8'h55}});
    expect_rsp("t2", 16'h33, {64{8'h55}});

    // Throttle and ordering on the RSP_GAP=2 instance
    wait_drain();
    offs.delete(); tags.delete();
    for (int j = 0; j < 30; j++) begin
      if (j < 6) drive(1, 42'($urandom_range(0, 255)), 16'(j), 0, '0, '0, '0);
      else       idle();
      #2;
      if (o_c0v[0]) begin
        offs.push_back(j + 1);
        tags.push_back(o_c0m[0]);
      end
    end
    chk("t3_count", 512'(offs.size()), 512'(6));
    for (int j = 0; j < 6 && j < offs.size(); j++) begin
      chk($sformatf("t3_offset_%0d", j), 512'(offs[j]), 512'(8 + 3 * j));
      chk($sformatf("t3_tag_%0d", j), 512'(tags[j]), 512'(j));
    end

    // Fill the RSP_GAP=20 instance while its gap counter blocks pops
    wait_drain();
    drive(1, 42'h9, 16'h200, 0, '0, '0, '0);
    seen = 0;
    for (k = 0; k < 60 && !seen; k++) begin
      idle();
      #2;
      if (o_c0v[1]) seen = 1;
    end
    chk("t4_preread_seen", 512'(seen), 512'(1));
    for (int j = 0; j < 17; j++) begin
      drive(1, 42'(j), 16'(16'h100 + j), 0, '0, '0, '0);
      #2;
      chk($sformatf("t4_almfull_%0d", j), 512'(o_c0alm[1]), 512'(j + 1 >= 12));
      chk($sformatf("t4_overflow_%0d", j), 512'(o_ovf[1]), 512'(j == 16));
    end
    tags.delete();
    for (int j = 0; j < 380; j++) begin
      idle();
      #2;
      if (o_c0v[1]) tags.push_back(o_c0m[1]);
    end
    chk("t4_rsp_count", 512'(tags.size()), 512'(16));
    for (int j = 0; j < 16 && j < tags.size(); j++)
      chk($sformatf("t4_tag_%0d", j), 512'(tags[j]), 512'(16'h100 + j));

    // Out-of-range addresses
    wait_drain();
    drive(0, '0, '0, 1, 42'h0, 16'h40, {16{32'h0BADF00D}});
    #2;
    chk("t5_aerr_before", 512'(o_aerr[0]), 512'(0));
    drive(1, 42'h100, 16'h44, 0, '0, '0, '0);
    #2;
    chk("t5_aerr_read", 512'(o_aerr[0]), 512'(1));
    expect_rsp("t5_oor", 16'h44, 512'(0));
    drive(0, '0, '0, 1, 42'h100, 16'h45, {16{32'hDEADBEEF}});
    #2;
    chk("t5_oor_ack", 512'(o_c1v[0]), 512'(1));
    chk("t5_oor_ack_mdata", 512'(o_c1m[0]), 512'(16'h45));
    drive(1, 42'h0, 16'h46, 0, '0, '0, '0);
    expect_rsp("t5_alias", 16'h46, {16{32'h0BADF00D}});

    // Reset with reads in flight
    wait_drain();
    drive(0, '0, '0, 1, 42'h7, 16'h50, {16{32'h12345678}});
    for (int j = 0; j < 4; j++) drive(1, 42'h7, 16'(16'h60 + j), 0, '0, '0, '0);
    @(negedge clk);
    reset = 1'b1;
    c0tx_valid = 0; c1tx_valid = 0;
    #1;
    chk_zero("midreset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int j = 0; j < 40; j++) begin
      idle();
      #2;
      if (o_c0v[0] || o_c0v[1] || o_c1v[0] || o_c1v[1]) seen++;
    end
    chk("t6_no_stale", 512'(seen), 512'(0));
    drive(1, 42'h7, 16'h70, 0, '0, '0, '0);
    expect_rsp("t6_mem_kept", 16'h70, {16{32'h12345678}});

    // Randomized traffic, long enough to wrap the 16-bit cycle counter
    for (int n = 0; n < 70000; n++) begin
      rv = ($urandom_range(0, 99) < (((n / 5000) % 2 == 0) ? 70 : 20));
      wv = ($urandom_range(0, 99) < 40);
      ra = 42'($urandom_range(0, 255));
      wa = 42'($urandom_range(0, 255));
      if ($urandom_range(0, 99) < 2) ra = ra | (42'($urandom_range(1, 1000)) << 8);
      if ($urandom_range(0, 99) < 2) wa = wa | (42'($urandom_range(1, 1000)) << 8);
      if (wv && $urandom_range(0, 9) == 0) wa = ra;
      for (int w = 0; w < 16; w++) wd[w*32 +: 32] = $urandom();
      drive(rv, ra, 16'($urandom()), wv, wa, 16'($urandom()), wd);
    end
    idle();
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
